// File: rtl/xof_triple_feeder.sv
// xof_triple_feeder: repacks BLK_W-bit keystream blocks into a NUM_BYTES byte stream of 3-byte groups
// PARSE_PRECOMP_EN adds the d1/d2 12-bit candidates and their < Q flags
module xof_triple_feeder #(
   parameter int BLK_W     = 128,
   parameter int NUM_BYTES = 768,
   parameter int BUF_BYTES = 32,
   parameter int Q         = 3329
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             blk_valid,
   input  logic [BLK_W-1:0] blk_data,
   output logic             blk_ready,
   output logic             tri_valid,
   output logic [23:0]      tri_data,
   input  logic             tri_ready,
   output logic             busy,
   output logic             done
`ifdef PARSE_PRECOMP_EN
   ,
   output logic [11:0]      d1,
   output logic [11:0]      d2,
   output logic             d1_ok,
   output logic             d2_ok
`endif
);
   localparam int BB = BLK_W / 8;
   localparam int PW = $clog2(BUF_BYTES);
   localparam int OW = $clog2(BUF_BYTES + 1);
   localparam int AW = $clog2(NUM_BYTES + 1);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state, state_n;
   logic [7:0] mem [BUF_BYTES];
   logic [PW-1:0] head, tail;
   logic [OW-1:0] occ;
   logic [AW-1:0] acc;
   logic active, push, pop, flush;
   // offsets never exceed BUF_BYTES, so one conditional subtract wraps
   function automatic logic [PW-1:0] wrap(input int p);
      return PW'(p >= BUF_BYTES ? p - BUF_BYTES : p);
   endfunction
   assign active    = state == RUN || state == DRAIN;
   assign busy      = active;
   assign done      = state == DONE;
   assign blk_ready = state == RUN && occ <= OW'(BUF_BYTES - BB) && acc < AW'(NUM_BYTES);
   assign tri_valid = active && occ >= OW'(3);
   assign tri_data  = tri_valid ? {mem[wrap(int'(head) + 2)], mem[wrap(int'(head) + 1)], mem[head]} : 24'd0;
   assign push      = blk_valid && blk_ready;
   assign pop       = tri_valid && tri_ready;
   assign flush     = start || (abort && active);
   always_comb begin
      state_n = state;
      if (start)
         state_n = RUN;
      else if (abort && active)
         state_n = DONE;
      else if (state == RUN && push && int'(acc) + BB >= NUM_BYTES)
         state_n = DRAIN;
      else if (state == DRAIN && occ == '0)
         state_n = DONE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         head  <= '0;
         tail  <= '0;
         occ   <= '0;
         acc   <= '0;
      end else begin
         state <= state_n;
         if (flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            acc  <= '0;
         end else begin
            if (push) begin
               tail <= wrap(int'(tail) + BB);
               acc  <= acc + AW'(BB);
            end
            if (pop)
               head <= wrap(int'(head) + 3);
            occ <= occ + (push ? OW'(BB) : OW'(0)) - (pop ? OW'(3) : OW'(0));
         end
      end
   end
   always_ff @(posedge clk)
      if (push)
         for (int k = 0; k < BB; k++)
            mem[wrap(int'(tail) + k)] <= blk_data[8*k +: 8];
`ifdef PARSE_PRECOMP_EN
   assign d1    = {tri_data[11:8], tri_data[7:0]};
   assign d2    = {tri_data[23:16], tri_data[15:12]};
   assign d1_ok = tri_valid && d1 < 12'(Q);
   assign d2_ok = tri_valid && d2 < 12'(Q);
`endif
endmodule

// File: tb/tb_xof_triple_feeder.sv
// tb_xof_triple_feeder: vector table for the repack/abort corners, then randomized runs against a byte-queue model
module tb_xof_triple_feeder;
   logic clk = 0, rst = 1, start = 0, abort = 0, blk_valid = 0, tri_ready = 0;
   logic [127:0] blk_data = '0;
   logic blk_ready, tri_valid, busy, done;
   logic [23:0] tri_data;
`ifdef PARSE_PRECOMP_EN
   logic [11:0] d1, d2;
   logic d1_ok, d2_ok;
`endif
   int tests = 0, fails = 0;

   xof_triple_feeder dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(blk_ready),
      .tri_valid(tri_valid), .tri_data(tri_data), .tri_ready(tri_ready),
      .busy(busy), .done(done)
`ifdef PARSE_PRECOMP_EN
      , .d1(d1), .d2(d2), .d1_ok(d1_ok), .d2_ok(d2_ok)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic st, ab, bv;
      logic [127:0] bd;
      logic tr;
      logic e_br, e_tv;
      logic [23:0] e_td;
      logic e_busy, e_done;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %0s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] blk(input logic [7:0] b);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[8*k +: 8] = b + 8'(k);
      return r;
   endfunction

   function automatic vec_t mk(input logic st, ab, bv, input logic [127:0] bd, input logic tr,
                               input logic br, tv, input logic [23:0] td, input logic bs, dn);
      vec_t v;
      v.st = st; v.ab = ab; v.bv = bv; v.bd = bd; v.tr = tr;
      v.e_br = br; v.e_tv = tv; v.e_td = td; v.e_busy = bs; v.e_done = dn;
      return v;
   endfunction

   // Model: the buffer is a byte queue; a block may enter while at most 16 bytes are held
   task automatic run(input int pv, input int pr, input int hold, input int abort_at, input bit rst_drain);
      logic [7:0] q[$];
      int sent = 0, trip = 0, nblk = 0, cyc = 0;
      bit fin = 0, can_push, can_pop;
      @(negedge clk);
      start = 1; abort = 0; blk_valid = 0; tri_ready = 0;
      @(negedge clk);
      start = 0;
      while (!fin && cyc < 20000) begin
         cyc++;
         can_push = q.size() <= 16 && sent < 768;
         can_pop  = q.size() >= 3;
         chk("blk_ready", blk_ready, can_push);
         chk("tri_valid", tri_valid, can_pop);
         chk("busy", busy, 1);
         if (can_pop) chk("tri_data", tri_data, {q[2], q[1], q[0]});
         if (hold > 0 && cyc == hold + 1) chk("bp_blocks", nblk, 2);
         blk_valid = cyc <= hold ? 1'b1 : $urandom_range(99) < pv;
         tri_ready = cyc <= hold ? 1'b0 : $urandom_range(99) < pr;
         blk_data  = {$urandom, $urandom, $urandom, $urandom};
         abort     = abort_at >= 0 && trip == abort_at;
         rst       = rst_drain && sent == 768 && q.size() > 0;
         if (can_pop && tri_ready) begin
            repeat (3) void'(q.pop_front());
            trip++;
         end
         if (can_push && blk_valid) begin
            for (int k = 0; k < 16; k++) q.push_back(blk_data[8*k +: 8]);
            sent += 16;
            nblk++;
         end
         if (abort || rst) begin
            @(negedge clk);
            chk("stop_done", done, abort);
            chk("stop_busy", busy, 0);
            chk("stop_tri_valid", tri_valid, 0);
            chk("stop_tri_data", tri_data, 0);
            chk("stop_blk_ready", blk_ready, 0);
            abort = 0; rst = 0; blk_valid = 0; tri_ready = 0;
            return;
         end
         fin = trip == 256;
         @(negedge clk);
      end
      blk_valid = 0; tri_ready = 0;
      chk("run_finished", fin, 1);
      for (int w = 0; w < 8 && !done; w++) @(negedge clk);
      chk("done_after_run", done, 1);
      chk("triples", trip, 256);
      chk("blocks", nblk, 48);
      chk("blk_ready_done", blk_ready, 0);
      chk("busy_done", busy, 0);
   endtask

   initial begin
      vec_t v[18];
      v[0]  = mk(0, 0, 0, '0,         0, 0, 0, 24'h0,      0, 0);
      v[1]  = mk(1, 0, 0, '0,         0, 0, 0, 24'h0,      0, 0);
      v[2]  = mk(0, 0, 1, blk(8'h00), 1, 1, 0, 24'h0,      1, 0);
      v[3]  = mk(0, 0, 0, '0,         1, 1, 1, 24'h020100, 1, 0);
      v[4]  = mk(0, 0, 0, '0,         1, 1, 1, 24'h050403, 1, 0);
      v[5]  = mk(0, 0, 0, '0,         1, 1, 1, 24'h080706, 1, 0);
      v[6]  = mk(0, 0, 0, '0,         1, 1, 1, 24'h0B0A09, 1, 0);
      v[7]  = mk(0, 0, 0, '0,         1, 1, 1, 24'h0E0D0C, 1, 0);
      v[8]  = mk(0, 0, 1, blk(8'h10), 1, 1, 0, 24'h0,      1, 0);
      v[9]  = mk(0, 0, 0, '0,         0, 0, 1, 24'h11100F, 1, 0);
      v[10] = mk(0, 1, 0, '0,         0, 0, 1, 24'h11100F, 1, 0);
      v[11] = mk(0, 0, 0, '0,         0, 0, 0, 24'h0,      0, 1);
      v[12] = mk(0, 1, 0, '0,         0, 0, 0, 24'h0,      0, 1);
      v[13] = mk(1, 0, 0, '0,         0, 0, 0, 24'h0,      0, 1);
      v[14] = mk(0, 0, 1, blk(8'h20), 0, 1, 0, 24'h0,      1, 0);
      v[15] = mk(0, 0, 0, '0,         1, 1, 1, 24'h222120, 1, 0);
      v[16] = mk(1, 1, 0, '0,         1, 1, 1, 24'h252423, 1, 0);
      v[17] = mk(0, 0, 0, '0,         0, 1, 0, 24'h0,      1, 0);
      repeat (2) @(negedge clk);
      rst = 0;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         chk($sformatf("vec%0d_blk_ready", i), blk_ready, v[i].e_br);
         chk($sformatf("vec%0d_tri_valid", i), tri_valid, v[i].e_tv);
         chk($sformatf("vec%0d_tri_data", i), tri_data, v[i].e_td);
         chk($sformatf("vec%0d_busy", i), busy, v[i].e_busy);
         chk($sformatf("vec%0d_done", i), done, v[i].e_done);
         start = v[i].st; abort = v[i].ab; blk_valid = v[i].bv; blk_data = v[i].bd; tri_ready = v[i].tr;
      end
`ifdef PARSE_PRECOMP_EN
      @(negedge clk);
      chk("pre_d1_idle", d1, 0);
      chk("pre_d1_ok_idle", d1_ok, 0);
      chk("pre_d2_ok_idle", d2_ok, 0);
      start = 1; blk_valid = 0; tri_ready = 0; abort = 0;
      @(negedge clk);
      start = 0; blk_valid = 1; blk_data = {104'h0, 24'hD00D01};
      @(negedge clk);
      blk_valid = 0;
      chk("pre_d1", d1, 3329);
      chk("pre_d1_ok", d1_ok, 0);
      chk("pre_d2", d2, 3328);
      chk("pre_d2_ok", d2_ok, 1);
`endif
      run(60, 60, 0, -1, 0);
      run(80, 70, 8, -1, 0);
      run(70, 70, 0, 85, 0);
      run(50, 50, 0, -1, 0);
      run(90, 30, 0, -1, 1);
      run(60, 60, 0, -1, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/xof_triple_feeder.md
Name: xof_triple_feeder

Overview:
- Upstream neighbour of the parse stage in the Kyber-768-90s matrix-generation path.
- Accepts 128-bit AES-256-CTR keystream blocks from the XOF wrapper and repacks them into an exact byte stream of NUM_BYTES bytes.
- Emits the stream as 3-byte groups, the unit parse consumes per rejection-sampling iteration.
- A small byte buffer absorbs the 16-byte vs 3-byte misalignment and provides backpressure both ways.

Parameters:
- BLK_W, 128, keystream block width in bits (multiple of 8).
- NUM_BYTES, 768, bytes delivered per run (multiple of 3 and of BLK_W/8).
- BUF_BYTES, 32, byte buffer capacity (>= 2*BLK_W/8).
- Q, 3329, modulus (used only with the optional feature).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new run.
- abort  in  1  one-cycle pulse from parse (256 coefficients filled); ends run early.
- blk_valid  in  1  keystream block valid.
- blk_data  in  BLK_W  keystream block; byte k = blk_data[8k+7:8k].
- blk_ready  out  1  block accepted when blk_valid && blk_ready.
- tri_valid  out  1  triple available.
- tri_data  out  24  {b2,b1,b0}, b0 = oldest byte.
- tri_ready  in  1  triple consumed when tri_valid && tri_ready.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE; held until next start.

Behaviour:
- Clocking: single clock clk; rst is synchronous, active-high.
- Reset: state=IDLE; occupancy=0; accepted-byte count=0; all outputs 0. Reset mid-run discards buffer contents and counts.
- IDLE:
  - blk_ready=0, tri_valid=0.
  - start -> RUN, clearing buffer and counts.
- RUN:
  - blk_ready = (occ <= BUF_BYTES-BLK_W/8) && (acc_bytes < NUM_BYTES). Registered occupancy only; a same-cycle pop does not raise blk_ready.
  - tri_valid = (occ >= 3). tri_data is driven from registered buffer head.
  - Accept: append BLK_W/8 bytes in byte order 0..15; acc_bytes += 16.
  - Pop: remove 3 head bytes.
  - Simultaneous accept and pop in one cycle: occ_next = occ + 16 - 3.
  - Latency: block accepted at edge N -> tri_valid visible in cycle N+1 if occ_next >= 3.
  - acc_bytes reaches NUM_BYTES -> DRAIN.
- DRAIN:
  - blk_ready=0.
  - Triples continue to be emitted.
  - occ==0 -> DONE. NUM_BYTES%3==0 guarantees no partial triple remains.
- DONE:
  - done=1, busy=0, tri_valid=0.
  - start -> RUN (done clears that cycle).
- abort in RUN or DRAIN:
  - Next cycle state=DONE, occ=0, remaining bytes dropped.
  - A pop in the abort cycle still completes.
- abort in IDLE or DONE: ignored.
- start in RUN or DRAIN: restart. Buffer flushed, counts cleared, remain in RUN; any block or triple handshake in that cycle is discarded.
- start and abort in the same cycle: start wins.
- Buffer: circular, head/tail pointers mod BUF_BYTES, occupancy counter 0..BUF_BYTES. Overflow is impossible by the blk_ready rule.
- Invariant: total triples emitted per completed run = NUM_BYTES/3 = 256.

Optional Feature:
- Macro: PARSE_PRECOMP_EN.
- When defined, add outputs:
  - d1 out 12 = b0 + 256*(b1 mod 16).
  - d2 out 12 = (b1 >> 4) + 16*b2.
  - d1_ok out 1 = (d1 < Q).
  - d2_ok out 1 = (d2 < Q).
- These outputs are combinational from tri_data, valid only with tri_valid, and 0 when tri_valid=0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Basic repack: start, one block with bytes 0x00..0x0F, tri_ready=1 -> triples 0x020100, 0x050403, 0x080706, 0x0B0A09, 0x0E0D0C; 1 byte (0x0F) left; tri_valid=0. Next block 0x10..0x1F -> first triple 0x11100F.
- Full run: 48 blocks, random valid/ready gaps -> exactly 256 triples matching a byte-order model; done=1 after last pop; blk_ready never high after the 48th block.
- Backpressure: tri_ready=0, blocks offered continuously -> exactly 2 blocks accepted (occ=32), blk_ready=0. Release tri_ready -> blk_ready returns when occ <= 16, no byte lost or duplicated.
- Abort/restart: abort after 85 triples -> DONE next cycle, occ=0. start -> new run's first triple built from the new block's bytes 0..2 only.
- Reset mid-run: rst for 1 cycle during DRAIN -> all outputs 0 next cycle, state IDLE; start re-runs cleanly.
- PARSE_PRECOMP_EN: triple bytes b0=0x01, b1=0x0D, b2=0xD0 -> d1=3329, d1_ok=0, d2=3328, d2_ok=1.
